// File: rtl/bar_motion_ctrl.sv
// rtl/bar_motion_ctrl.sv - frame-synchronous player object position sequencer with per-pixel object flag
module bar_motion_ctrl #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int OBJ_W  = 80,
    parameter int OBJ_H  = 50,
    parameter int X_INIT = 110,
    parameter int Y_INIT = 55,
    parameter int STEP   = 2
) (
    input  logic       iclk,
    input  logic       ireset,
    input  logic       iframe_tick,
    input  logic       ienable,
    input  logic       irestart,
    input  logic       ibtn_left,
    input  logic       ibtn_right,
    input  logic       ibtn_up,
    input  logic       ibtn_down,
    input  logic [9:0] ipixel_x,
    input  logic [9:0] ipixel_y,
    output logic [9:0] oobj_x,
    output logic [9:0] oobj_y,
    output logic       oobj_on,
    output logic       ohit_edge,
    output logic [1:0] ostate
);

    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] X_MAX_W = 11'(H_RES - OBJ_W);
    localparam logic [10:0] Y_MAX_W = 11'(V_RES - OBJ_H);
    localparam logic [10:0] OBJ_W_W = 11'(OBJ_W);
    localparam logic [10:0] OBJ_H_W = 11'(OBJ_H);
    localparam logic [9:0]  X_INIT_W = 10'(X_INIT);
    localparam logic [9:0]  Y_INIT_W = 10'(Y_INIT);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t      state;
    logic [9:0]  obj_x;
    logic [9:0]  obj_y;
    logic        obj_on;
    logic        hit_edge;

    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [10:0] x_sum;
    logic [10:0] y_sum;
    logic [10:0] x_cand;
    logic [10:0] y_cand;
    logic        x_hit;
    logic        y_hit;
    logic        move_en;
    logic        pix_in;

    assign x_ext = {1'b0, obj_x};
    assign y_ext = {1'b0, obj_y};
    assign x_sum = x_ext + STEP_W;
    assign y_sum = y_ext + STEP_W;

    assign move_en = iframe_tick && (state == RUN) && ienable;

    // Subtraction is guarded by a compare so the 11-bit path never wraps.
    always_comb begin
        x_cand = x_ext;
        x_hit  = 1'b0;
        if (ibtn_left && !ibtn_right) begin
            if (x_ext >= STEP_W) begin
                x_cand = x_ext - STEP_W;
            end else begin
                x_cand = 11'd0;
                x_hit  = 1'b1;
            end
        end else if (ibtn_right && !ibtn_left) begin
            if (x_sum > X_MAX_W) begin
                x_cand = X_MAX_W;
                x_hit  = 1'b1;
            end else begin
                x_cand = x_sum;
            end
        end
    end

    always_comb begin
        y_cand = y_ext;
        y_hit  = 1'b0;
        if (ibtn_up && !ibtn_down) begin
            if (y_ext >= STEP_W) begin
                y_cand = y_ext - STEP_W;
            end else begin
                y_cand = 11'd0;
                y_hit  = 1'b1;
            end
        end else if (ibtn_down && !ibtn_up) begin
            if (y_sum > Y_MAX_W) begin
                y_cand = Y_MAX_W;
                y_hit  = 1'b1;
            end else begin
                y_cand = y_sum;
            end
        end
    end

    assign pix_in = ({1'b0, ipixel_x} > x_ext) && ({1'b0, ipixel_x} < (x_ext + OBJ_W_W)) &&
                    ({1'b0, ipixel_y} > y_ext) && ({1'b0, ipixel_y} < (y_ext + OBJ_H_W));

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state    <= IDLE;
            obj_x    <= X_INIT_W;
            obj_y    <= Y_INIT_W;
            obj_on   <= 1'b0;
            hit_edge <= 1'b0;
        end else begin
            obj_on <= pix_in;
            if (irestart) begin
                state    <= IDLE;
                obj_x    <= X_INIT_W;
                obj_y    <= Y_INIT_W;
                hit_edge <= 1'b0;
            end else begin
                hit_edge <= move_en && (x_hit || y_hit);
                if (move_en) begin
                    obj_x <= x_cand[9:0];
                    obj_y <= y_cand[9:0];
                end
                if (iframe_tick) begin
                    case (state)
                        IDLE:    if (ienable)  state <= RUN;
                        RUN:     if (!ienable) state <= PAUSE;
                        PAUSE:   if (ienable)  state <= RUN;
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign oobj_x    = obj_x;
    assign oobj_y    = obj_y;
    assign oobj_on   = obj_on;
    assign ohit_edge = hit_edge;
    assign ostate    = state;

endmodule
